// File: rtl/mul_responder_if.sv
// Request/response bundle for mul_responder: two requester channels (A, B),
// each with a valid/ready request side and a one-cycle response pulse.
interface mul_responder_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_vld_a, req_vld_b;
  logic             req_rdy_a, req_rdy_b;
  logic [26:0]      req_in_1_a, req_in_1_b;
  logic [26:0]      req_in_2_a, req_in_2_b;
  logic [TAG_W-1:0] req_tag_a, req_tag_b;
  logic             rsp_vld_a, rsp_vld_b;
  logic [53:0]      rsp_out_a, rsp_out_b;
  logic [TAG_W-1:0] rsp_tag_a, rsp_tag_b;

  modport master (
    output req_vld_a, req_vld_b, req_in_1_a, req_in_1_b,
           req_in_2_a, req_in_2_b, req_tag_a, req_tag_b,
    input  req_rdy_a, req_rdy_b, rsp_vld_a, rsp_vld_b,
           rsp_out_a, rsp_out_b, rsp_tag_a, rsp_tag_b
  );

  modport slave (
    input  req_vld_a, req_vld_b, req_in_1_a, req_in_1_b,
           req_in_2_a, req_in_2_b, req_tag_a, req_tag_b,
    output req_rdy_a, req_rdy_b, rsp_vld_a, rsp_vld_b,
           rsp_out_a, rsp_out_b, rsp_tag_a, rsp_tag_b
  );
endinterface

// File: rtl/mul_responder.sv
// Shared 27x27 unsigned multiplier serving two requesters with a fixed-latency pipeline.
// MUL_RESPONDER_RR_EN selects round-robin arbitration; otherwise channel A has fixed priority.
module mul_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  mul_responder_if.slave bus,
  output logic [2:0]     inflight,
  output logic           idle
);
  logic             grant_a, grant_b, acc;
  logic             s1_vld, s1_ch;
  logic [TAG_W-1:0] s1_tag;
  logic [26:0]      s1_op1, s1_op2;
  logic             st_vld  [2:LAT];
  logic             st_ch   [2:LAT];
  logic [TAG_W-1:0] st_tag  [2:LAT];
  logic [53:0]      st_prod [2:LAT];
  logic             out_vld, out_ch;
  logic [TAG_W-1:0] out_tag;
  logic [53:0]      out_prod;
`ifdef MUL_RESPONDER_RR_EN
  logic             last;
`endif

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && !flush) begin
      if (bus.req_vld_a && bus.req_vld_b) begin
`ifdef MUL_RESPONDER_RR_EN
        grant_a = last;
        grant_b = ~last;
`else
        grant_a = 1'b1;
`endif
      end else begin
        grant_a = bus.req_vld_a;
        grant_b = bus.req_vld_b;
      end
    end
  end

  assign bus.req_rdy_a = grant_a;
  assign bus.req_rdy_b = grant_b;
  assign acc           = grant_a | grant_b;

`ifdef MUL_RESPONDER_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    last <= 1'b0;
    else if (acc) last <= grant_b;
  end
`endif

  // Final stage feeds a registered output; flush also blocks that hand-off,
  // so a result still inside the pipe at the flush edge is never reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_ch    <= 1'b0;
      s1_tag   <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      for (int unsigned k = 2; k <= LAT; k++) begin
        st_vld[k]  <= 1'b0;
        st_ch[k]   <= 1'b0;
        st_tag[k]  <= '0;
        st_prod[k] <= '0;
      end
      out_vld  <= 1'b0;
      out_ch   <= 1'b0;
      out_tag  <= '0;
      out_prod <= '0;
      inflight <= '0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_ch  <= grant_b;
        s1_tag <= grant_b ? bus.req_tag_b  : bus.req_tag_a;
        s1_op1 <= grant_b ? bus.req_in_1_b : bus.req_in_1_a;
        s1_op2 <= grant_b ? bus.req_in_2_b : bus.req_in_2_a;
      end
      st_vld[2]  <= s1_vld & ~flush;
      st_ch[2]   <= s1_ch;
      st_tag[2]  <= s1_tag;
      st_prod[2] <= {27'd0, s1_op1} * {27'd0, s1_op2};
      for (int unsigned k = 3; k <= LAT; k++) begin
        st_vld[k]  <= st_vld[k-1] & ~flush;
        st_ch[k]   <= st_ch[k-1];
        st_tag[k]  <= st_tag[k-1];
        st_prod[k] <= st_prod[k-1];
      end
      out_vld  <= st_vld[LAT] & ~flush;
      out_ch   <= st_ch[LAT];
      out_tag  <= st_tag[LAT];
      out_prod <= st_prod[LAT];
      if (flush) inflight <= '0;
      else       inflight <= inflight + {2'b00, acc} - {2'b00, st_vld[LAT]};
    end
  end

  always_comb begin
    bus.rsp_vld_a = out_vld & ~out_ch;
    bus.rsp_vld_b = out_vld &  out_ch;
    bus.rsp_out_a = '0;
    bus.rsp_tag_a = '0;
    bus.rsp_out_b = '0;
    bus.rsp_tag_b = '0;
    if (out_vld && !out_ch) begin
      bus.rsp_out_a = out_prod;
      bus.rsp_tag_a = out_tag;
    end
    if (out_vld && out_ch) begin
      bus.rsp_out_b = out_prod;
      bus.rsp_tag_b = out_tag;
    end
  end

  assign idle = reset | ((inflight == 3'd0) & ~bus.req_vld_a & ~bus.req_vld_b);
endmodule

// File: tb/tb_mul_responder.sv
// Self-checking bench for mul_responder: directed tables and sequences plus
// randomized traffic checked against a queue-based reference model.
module tb_mul_responder;
  localparam int unsigned LAT   = 2;
  localparam int unsigned TAG_W = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] inflight;
  logic       idle;

  mul_responder_if #(.TAG_W(TAG_W)) bus ();

  mul_responder #(.LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  always @(posedge clk) e <= e + 1;

  typedef struct {
    int               due;
    bit               ch;
    logic [63:0]      prod;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    bit               ch;
    logic [26:0]      a;
    logic [26:0]      b;
    logic [TAG_W-1:0] tag;
    logic [53:0]      prod;
  } vec_t;

  exp_t        q[$];
  bit          m_last = 1'b0;
  bit          m_acc_a = 1'b0, m_acc_b = 1'b0;
  int          acc_log[$];
  logic [63:0] rsp_log[$];
  int          rsp_edge[$];
  int          rsp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] rnd27();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return 27'($urandom());
    endcase
  endfunction

  // Reference model: sampled mid-cycle, decides the coming edge's accept.
  always @(negedge clk) begin
    logic        va, vb, ea, eb, xa, xb;
    logic [63:0] pa, pb;
    logic [TAG_W-1:0] ta, tbg;
    int          infl;
    exp_t        n;
    va = bus.req_vld_a;
    vb = bus.req_vld_b;
    if (reset) begin
      q.delete();
      m_last = 1'b0;
    end
    ea = 1'b0;
    eb = 1'b0;
    if (!reset && !flush) begin
      if (va && vb) begin
`ifdef MUL_RESPONDER_RR_EN
        eb = (m_last == 1'b0);
        ea = !eb;
`else
        ea = 1'b1;
`endif
      end else begin
        ea = va;
        eb = vb;
      end
    end
    xa = 0; xb = 0; pa = 0; pb = 0; ta = 0; tbg = 0;
    if (q.size() > 0 && q[0].due == e) begin
      if (q[0].ch) begin xb = 1; pb = q[0].prod; tbg = q[0].tag; end
      else         begin xa = 1; pa = q[0].prod; ta  = q[0].tag; end
    end
    infl = 0;
    foreach (q[i]) if (q[i].due > e) infl++;
    chk("rdy_a", bus.req_rdy_a, ea);
    chk("rdy_b", bus.req_rdy_b, eb);
    chk("rsp_vld_a", bus.rsp_vld_a, xa);
    chk("rsp_out_a", bus.rsp_out_a, pa);
    chk("rsp_tag_a", bus.rsp_tag_a, ta);
    chk("rsp_vld_b", bus.rsp_vld_b, xb);
    chk("rsp_out_b", bus.rsp_out_b, pb);
    chk("rsp_tag_b", bus.rsp_tag_b, tbg);
    chk("inflight", inflight, infl);
    chk("idle", idle, reset ? 1 : (infl == 0 && !va && !vb));
    if (bus.req_vld_a && bus.req_rdy_a) acc_log.push_back(0);
    if (bus.req_vld_b && bus.req_rdy_b) acc_log.push_back(1);
    if (bus.rsp_vld_a) begin rsp_log.push_back(bus.rsp_out_a); rsp_edge.push_back(e); rsp_cnt++; end
    if (bus.rsp_vld_b) begin rsp_log.push_back(bus.rsp_out_b); rsp_edge.push_back(e); rsp_cnt++; end
    if (!reset) begin
      while (q.size() > 0 && q[0].due <= e) void'(q.pop_front());
      if (flush) q.delete();
      else if (ea || eb) begin
        n.due  = e + 1 + int'(LAT);
        n.ch   = eb;
        n.prod = eb ? 64'(bus.req_in_1_b) * 64'(bus.req_in_2_b)
                    : 64'(bus.req_in_1_a) * 64'(bus.req_in_2_a);
        n.tag  = eb ? bus.req_tag_b : bus.req_tag_a;
        q.push_back(n);
        m_last = eb;
      end
    end
    m_acc_a = ea && va;
    m_acc_b = eb && vb;
  end

  initial begin
    vec_t        tbl[6];
    int          exp_acc[5];
    logic [63:0] exp_prod[5];
    int          snap;

    tbl[0] = '{0, 27'h7ffffff, 27'h7ffffff, 4'h5, 54'h3FFFFFF0000001};
    tbl[1] = '{1, 27'd3,       27'd5,       4'ha, 54'd15};
    tbl[2] = '{0, 27'd0,       27'h7ffffff, 4'h0, 54'd0};
    tbl[3] = '{1, 27'h4000000, 27'd2,       4'hf, 54'h8000000};
    tbl[4] = '{0, 27'd1234,    27'd5678,    4'h9, 54'd7006652};
    tbl[5] = '{1, 27'h7ffffff, 27'd1,       4'h3, 54'h7ffffff};
`ifdef MUL_RESPONDER_RR_EN
    exp_acc  = '{1, 0, 1, 0, 1};
    exp_prod = '{15, 14, 15, 14, 15};
`else
    exp_acc  = '{0, 0, 0, 0, 1};
    exp_prod = '{14, 14, 14, 14, 15};
`endif

    bus.req_vld_a = 0; bus.req_vld_b = 0;
    bus.req_in_1_a = 0; bus.req_in_2_a = 0; bus.req_tag_a = 0;
    bus.req_in_1_b = 0; bus.req_in_2_b = 0; bus.req_tag_b = 0;

    // Reset state, with requests presented during reset
    repeat (3) cyc();
    bus.req_vld_a = 1; bus.req_vld_b = 1;
    #1;
    chk("rst_rdy_a", bus.req_rdy_a, 0);
    chk("rst_rdy_b", bus.req_rdy_b, 0);
    chk("rst_idle", idle, 1);
    chk("rst_inflight", inflight, 0);
    bus.req_vld_a = 0; bus.req_vld_b = 0;
    cyc();
    reset = 0;

    // Contention straight after reset
    bus.req_in_1_a = 2; bus.req_in_2_a = 7; bus.req_tag_a = 1;
    bus.req_in_1_b = 3; bus.req_in_2_b = 5; bus.req_tag_b = 2;
    bus.req_vld_a = 1; bus.req_vld_b = 1;
    acc_log.delete(); rsp_log.delete();
    repeat (4) cyc();
    bus.req_vld_a = 0;
    cyc();
    bus.req_vld_b = 0;
    repeat (LAT + 2) cyc();
    chk("cont_acc_cnt", acc_log.size(), 5);
    chk("cont_rsp_cnt", rsp_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < acc_log.size()) chk("cont_order", acc_log[i], exp_acc[i]);
      if (i < rsp_log.size()) chk("cont_prod", rsp_log[i], exp_prod[i]);
    end

    // Table of isolated single requests
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].ch) begin
        bus.req_in_1_b = tbl[i].a; bus.req_in_2_b = tbl[i].b; bus.req_tag_b = tbl[i].tag; bus.req_vld_b = 1;
      end else begin
        bus.req_in_1_a = tbl[i].a; bus.req_in_2_a = tbl[i].b; bus.req_tag_a = tbl[i].tag; bus.req_vld_a = 1;
      end
      cyc();
      bus.req_vld_a = 0; bus.req_vld_b = 0;
      repeat (LAT) cyc();
      if (tbl[i].ch) begin
        chk("tbl_vld_b", bus.rsp_vld_b, 1);
        chk("tbl_out_b", bus.rsp_out_b, tbl[i].prod);
        chk("tbl_tag_b", bus.rsp_tag_b, tbl[i].tag);
        chk("tbl_other_a", bus.rsp_vld_a, 0);
      end else begin
        chk("tbl_vld_a", bus.rsp_vld_a, 1);
        chk("tbl_out_a", bus.rsp_out_a, tbl[i].prod);
        chk("tbl_tag_a", bus.rsp_tag_a, tbl[i].tag);
        chk("tbl_other_b", bus.rsp_vld_b, 0);
      end
      cyc();
      chk("tbl_pulse_end", bus.rsp_vld_a | bus.rsp_vld_b, 0);
    end

    // Full-throughput stream on A
    rsp_log.delete(); rsp_edge.delete();
    for (int i = 1; i <= 8; i++) begin
      bus.req_in_1_a = 27'(i); bus.req_in_2_a = 27'(i); bus.req_tag_a = TAG_W'(i); bus.req_vld_a = 1;
      cyc();
      if (i >= int'(LAT)) chk("stream_inflight", inflight, LAT);
    end
    bus.req_vld_a = 0;
    repeat (LAT + 2) cyc();
    chk("stream_cnt", rsp_log.size(), 8);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++) begin
      chk("stream_prod", rsp_log[i], (i + 1) * (i + 1));
      if (i > 0) chk("stream_b2b", rsp_edge[i], rsp_edge[i-1] + 1);
    end

    // Flush kills in-flight work and blocks the request in the flush cycle
    snap = rsp_cnt;
    bus.req_in_1_a = 5; bus.req_in_2_a = 6; bus.req_tag_a = 3; bus.req_vld_a = 1;
    cyc();
    bus.req_in_1_a = 7; bus.req_in_2_a = 8; bus.req_tag_a = 4;
    cyc();
    bus.req_vld_a = 0;
    bus.req_in_1_b = 9; bus.req_in_2_b = 9; bus.req_tag_b = 5; bus.req_vld_b = 1;
    flush = 1;
    #1;
    chk("flush_rdy_b", bus.req_rdy_b, 0);
    cyc();
    flush = 0; bus.req_vld_b = 0;
    chk("flush_inflight", inflight, 0);
    repeat (LAT + 3) cyc();
    chk("flush_no_rsp", rsp_cnt - snap, 0);

    // Asynchronous reset while a result is showing and another is in the pipe
    bus.req_in_1_a = 11; bus.req_in_2_a = 13; bus.req_tag_a = 6; bus.req_vld_a = 1;
    cyc();
    bus.req_in_1_a = 17; bus.req_in_2_a = 19; bus.req_tag_a = 7;
    cyc();
    bus.req_vld_a = 0;
    repeat (LAT - 1) cyc();
    chk("pre_rst_vld", bus.rsp_vld_a, 1);
    chk("pre_rst_inflight", inflight, 1);
    #1 reset = 1;
    #1;
    chk("arst_vld_a", bus.rsp_vld_a, 0);
    chk("arst_out_a", bus.rsp_out_a, 0);
    chk("arst_inflight", inflight, 0);
    chk("arst_idle", idle, 1);
    cyc(); cyc();
    reset = 0;
    snap = rsp_cnt;
    acc_log.delete();
    bus.req_in_1_a = 2; bus.req_in_2_a = 7; bus.req_tag_a = 1;
    bus.req_in_1_b = 3; bus.req_in_2_b = 5; bus.req_tag_b = 2;
    bus.req_vld_a = 1; bus.req_vld_b = 1;
    cyc();
`ifdef MUL_RESPONDER_RR_EN
    bus.req_vld_b = 0;
`else
    bus.req_vld_a = 0;
`endif
    cyc();
    bus.req_vld_a = 0; bus.req_vld_b = 0;
    repeat (LAT + 2) cyc();
    chk("post_rst_acc_cnt", acc_log.size(), 2);
    if (acc_log.size() > 0) chk("post_rst_winner", acc_log[0], exp_acc[0]);
    chk("post_rst_rsp_cnt", rsp_cnt - snap, 2);

    // Randomized traffic; an unaccepted request holds vld and payload
    for (int c = 0; c < 500; c++) begin
      if (!(bus.req_vld_a && !m_acc_a)) begin
        bus.req_vld_a  = ($urandom_range(0, 99) < 60);
        bus.req_in_1_a = rnd27(); bus.req_in_2_a = rnd27(); bus.req_tag_a = TAG_W'($urandom());
      end
      if (!(bus.req_vld_b && !m_acc_b)) begin
        bus.req_vld_b  = ($urandom_range(0, 99) < 60);
        bus.req_in_1_b = rnd27(); bus.req_in_2_b = rnd27(); bus.req_tag_b = TAG_W'($urandom());
      end
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    bus.req_vld_a = 0; bus.req_vld_b = 0; flush = 0;
    repeat (LAT + 3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_responder.md
# mul_responder

Shared 27x27 unsigned multiplier service that answers multiply requests from two requesters, e.g. the two partial-product lanes of the FMA datapath, instead of each requester owning its own multiplier. Each cycle it arbitrates the two request channels and accepts at most one request. The product flows through a fixed-latency pipeline and returns on the winning requester's response channel with the requester's tag echoed.

## Interface
- LAT, default 2: request-accept to response latency in cycles; legal range 2..4.
- TAG_W, default 4: width of the opaque request tag returned with each product.

- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  synchronous; kills all in-flight operations.
- req_vld_a / req_vld_b  in  1  request valid, channel A / B.
- req_rdy_a / req_rdy_b  out  1  request accepted this cycle.
- req_in_1_a / req_in_1_b  in  27  multiplicand.
- req_in_2_a / req_in_2_b  in  27  multiplier.
- req_tag_a / req_tag_b  in  TAG_W  tag.
- rsp_vld_a / rsp_vld_b  out  1  one-cycle result pulse.
- rsp_out_a / rsp_out_b  out  54  product.
- rsp_tag_a / rsp_tag_b  out  TAG_W  echoed tag.
- inflight  out  3  count of valid pipeline stages (0..LAT).
- idle  out  1  inflight==0 and no request valid.

## Operation
- Acceptance: a request is accepted on channel X when req_vld_X & req_rdy_X at a rising edge.
- req_rdy_X is combinational from req_vld_a, req_vld_b, the arbiter pointer, flush and reset.
- Ready is 0 during reset and during a flush cycle.
- Only one channel valid: that channel gets ready.
- Both channels valid: the arbiter picks the winner and the loser's ready stays 0. The loser must hold its vld and payload stable until accepted.
- Arbiter pointer `last`: 0 = A granted last, 1 = B granted last. Reset value 0.
  - On a contended cycle, the channel not equal to `last` wins, so B wins the first contention after reset.
  - `last` updates on every accept, contended or not.
- Pipeline: LAT stages, each holding valid, channel id, tag and a partial/complete product.
  - Stage 1 registers the operands.
  - The product is full 54-bit unsigned, req_in_1*req_in_2, no truncation or rounding.
  - The final stage drives rsp_*_X of the stored channel.
- No response backpressure: requesters always sink responses.
- Response fields not selected, or not valid: rsp_vld=0, rsp_out=0, rsp_tag=0.
- inflight: incremented on accept, decremented when the final stage retires. Simultaneous accept and retire leaves it unchanged. It never exceeds LAT.
- flush:
  - Clears all stage valids at the edge and sets inflight to 0.
  - Flushed requests produce no response.
  - A request presented in the flush cycle is not accepted.
  - `last` is unchanged.

## Timing
- Accept at edge N → rsp_vld at cycle N+LAT (registered output), high for exactly one cycle.
- Throughput: one accept per cycle aggregate; back-to-back accepts yield back-to-back responses in accept order.
- A and B responses never coincide, since at most one is accepted per cycle.
- Reset (asynchronous, any time, including mid-operation):
  - All stage valids, inflight and `last` clear immediately.
  - All rsp_* outputs read 0, req_rdy_* read 0, idle reads 1.
  - In-flight results are lost.
- After reset deasserts, the first accept is possible at the next edge.

## Configuration
- MUL_RESPONDER_RR_EN defined: round-robin arbitration as above.
- Not defined: fixed priority. Channel A always wins contention, `last` is not implemented, and B is served only when A is not valid.
- All other behaviour is identical in both builds.

## Test plan
- Single A request: in_1=27'h7ffffff, in_2=27'h7ffffff, tag=4'h5, LAT=2, accepted at edge N → rsp_vld_a=1 at N+2 with rsp_out_a=54'h3FFFFFF0000001 and rsp_tag_a=4'h5; rsp_vld_b stays 0.
- Contention (RR build): both channels valid for 4 cycles after reset with B operands 3*5 and A operands 2*7 → accept order B,A,B,A; responses alternate 54'd15 and 54'd14; loser ready=0 each cycle.
- Contention (fixed-priority build): same stimulus → A accepted 4 times, B never; B accepted on the first cycle after A drops vld.
- Full throughput: 8 consecutive A requests with operands i*i, i=1..8 → 8 consecutive rsp_vld_a pulses carrying 1,4,…,64 in order; inflight holds at LAT while streaming.
- Flush: accept 2 requests, assert flush on the next cycle with req_vld_b=1 → no responses ever appear, B is not accepted that cycle, and inflight=0 at the following edge.
- Asynchronous reset mid-pipe: accept a request, then raise reset between edges → rsp_* and inflight go 0 before the next edge; no response after release; the first post-reset contention is won by B (RR build).
